// File: rtl/reflet_uart_loader_pkg.sv
// Shared constants, loader FSM states and baud divisor helper for the UART program loader.
package reflet_uart_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] ACK_BYTE  = 8'h06;
   localparam logic [7:0] NAK_BYTE  = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_L,
      ST_LEN_H,
      ST_ADDR_L,
      ST_ADDR_H,
      ST_DATA,
      ST_CSUM,
      ST_REPLY
   } state_t;

   function automatic int baud_divisor(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/reflet_uart_loader_if.sv
// Loader-side serial pins and system-bus write port; master = loader, slave = system/host side.
interface reflet_uart_loader_if #(
   parameter int wordsize = 16
);
   logic                rx;
   logic                tx;
   logic                cpu_hold;
   logic [wordsize-1:0] addr;
   logic [wordsize-1:0] data_out;
   logic                write_en;

   modport master (input rx, output tx, cpu_hold, addr, data_out, write_en);
   modport slave  (output rx, input tx, cpu_hold, addr, data_out, write_en);
endinterface

// File: rtl/reflet_loader_serial.sv
// 8N1 bit engine: rx sampler (byte-valid pulse one cycle after stop-bit sample) and tx shifter.
// tx_vld is only taken while tx_busy is low; tx_done pulses in the last cycle of the stop bit.
module reflet_loader_serial #(
   parameter int DIV = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_dat,
   output logic       rx_vld,
   output logic       rx_ferr,
   input  logic [7:0] tx_dat,
   input  logic       tx_vld,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx
);
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(DIV / 2);

   logic          rx_s1_q, rx_s2_q, rx_s3_q;
   logic          rx_busy_q, rx_busy_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [3:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_vld_q, rx_vld_d;
   logic          rx_ferr_q, rx_ferr_d;

   logic          tx_busy_q, tx_busy_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]    tx_bit_q, tx_bit_d;
   logic [9:0]    tx_shift_q, tx_shift_d;
   logic          tx_done_c;

   // rx_cnt_q tracks cycles since the detected falling edge, modulo one bit time
   always_comb begin
      rx_busy_d  = rx_busy_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_vld_d   = 1'b0;
      rx_ferr_d  = 1'b0;
      if (!rx_busy_q) begin
         if (rx_s3_q && !rx_s2_q) begin
            rx_busy_d = 1'b1;
            rx_cnt_d  = CW'(1);
            rx_bit_d  = 4'd0;
         end
      end else begin
         rx_cnt_d = (rx_cnt_q == CNT_LAST) ? '0 : rx_cnt_q + 1'b1;
         if (rx_cnt_q == CNT_LAST)
            rx_bit_d = rx_bit_q + 1'b1;
         if (rx_cnt_q == CNT_MID) begin
            if (rx_bit_q == 4'd0) begin
               if (rx_s2_q)
                  rx_busy_d = 1'b0;
            end else if (rx_bit_q == 4'd9) begin
               rx_busy_d = 1'b0;
               rx_vld_d  = 1'b1;
               rx_ferr_d = !rx_s2_q;
            end else begin
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            end
         end
      end
   end

   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_done_c  = 1'b0;
      if (!tx_busy_q) begin
         if (tx_vld) begin
            tx_busy_d  = 1'b1;
            tx_cnt_d   = '0;
            tx_bit_d   = 4'd0;
            tx_shift_d = {1'b1, tx_dat, 1'b0};
         end
      end else if (tx_cnt_q == CNT_LAST) begin
         tx_cnt_d   = '0;
         tx_shift_d = {1'b1, tx_shift_q[9:1]};
         if (tx_bit_q == 4'd9) begin
            tx_busy_d = 1'b0;
            tx_done_c = 1'b1;
         end else begin
            tx_bit_d = tx_bit_q + 1'b1;
         end
      end else begin
         tx_cnt_d = tx_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_busy_q  <= 1'b0;
         rx_cnt_q   <= '0;
         rx_bit_q   <= 4'd0;
         rx_shift_q <= 8'h00;
         rx_vld_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
         tx_busy_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= 4'd0;
         tx_shift_q <= '1;
      end else begin
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
         rx_busy_q  <= rx_busy_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_vld_q   <= rx_vld_d;
         rx_ferr_q  <= rx_ferr_d;
         tx_busy_q  <= tx_busy_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
      end
   end

   assign rx_dat  = rx_shift_q;
   assign rx_vld  = rx_vld_q;
   assign rx_ferr = rx_ferr_q;
   assign tx_busy = tx_busy_q;
   assign tx_done = tx_done_c;
   assign tx      = tx_shift_q[0];
endmodule

// File: rtl/reflet_uart_loader.sv
// UART program loader: parses SYNC/LEN/ADDR/data[/CSUM] frames, writes bytes to the bus, replies ACK/NAK.
// REFLET_LOADER_CHECKSUM_EN adds a trailing checksum byte; without it every well-framed frame is ACKed.
module reflet_uart_loader
   import reflet_uart_loader_pkg::*;
#(
   parameter int wordsize  = 16,
   parameter int clk_freq  = 96000,
   parameter int baud_rate = 9600
) (
   input logic                  clk,
   input logic                  reset,
   reflet_uart_loader_if.master bus
);
   localparam int DIV = baud_divisor(clk_freq, baud_rate);

   logic [7:0] rx_dat;
   logic       rx_vld, rx_ferr;
   logic       tx_busy, tx_done, tx_line;
   logic       tx_vld_c;
   logic [7:0] tx_dat_c;
   logic       body_done;

   state_t              state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [wordsize-1:0] ptr_q, ptr_d;
   logic [wordsize-1:0] addr_q, addr_d;
   logic [wordsize-1:0] data_q, data_d;
   logic                we_q, we_d;
   logic                hold_q, hold_d;
   logic [7:0]          sum_q, sum_d;

   reflet_loader_serial #(.DIV(DIV)) u_serial (
      .clk     (clk),
      .reset   (reset),
      .rx      (bus.rx),
      .rx_dat  (rx_dat),
      .rx_vld  (rx_vld),
      .rx_ferr (rx_ferr),
      .tx_dat  (tx_dat_c),
      .tx_vld  (tx_vld_c && !tx_busy),
      .tx_busy (tx_busy),
      .tx_done (tx_done),
      .tx      (tx_line)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      ptr_d     = ptr_q;
      addr_d    = addr_q;
      data_d    = data_q;
      we_d      = 1'b0;
      hold_d    = hold_q;
      sum_d     = sum_q;
      tx_vld_c  = 1'b0;
      tx_dat_c  = ACK_BYTE;
      body_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_vld && !rx_ferr && rx_dat == SYNC_BYTE) begin
               state_d = ST_LEN_L;
               hold_d  = 1'b1;
               sum_d   = 8'h00;
            end
         end
         ST_REPLY: begin
            if (tx_done) begin
               state_d = ST_IDLE;
               hold_d  = 1'b0;
            end
         end
         default: begin
            if (rx_vld && rx_ferr) begin
               // Abort mid-frame; bytes already written to memory stay written
               state_d  = ST_REPLY;
               tx_vld_c = 1'b1;
               tx_dat_c = NAK_BYTE;
            end else if (rx_vld) begin
               sum_d = sum_q + rx_dat;
               case (state_q)
                  ST_LEN_L: begin
                     len_d[7:0] = rx_dat;
                     state_d    = ST_LEN_H;
                  end
                  ST_LEN_H: begin
                     len_d[15:8] = rx_dat;
                     state_d     = ST_ADDR_L;
                  end
                  ST_ADDR_L: begin
                     ptr_d   = wordsize'(rx_dat);
                     state_d = ST_ADDR_H;
                  end
                  ST_ADDR_H: begin
                     ptr_d = wordsize'({rx_dat, ptr_q[7:0]});
                     if (len_q == 16'd0)
                        body_done = 1'b1;
                     else
                        state_d = ST_DATA;
                  end
                  ST_DATA: begin
                     we_d   = 1'b1;
                     addr_d = ptr_q;
                     data_d = wordsize'(rx_dat);
                     ptr_d  = ptr_q + 1'b1;
                     len_d  = len_q - 1'b1;
                     if (len_q == 16'd1)
                        body_done = 1'b1;
                  end
                  ST_CSUM: begin
                     state_d  = ST_REPLY;
                     tx_vld_c = 1'b1;
                     tx_dat_c = (rx_dat == sum_q) ? ACK_BYTE : NAK_BYTE;
                  end
                  default: ;
               endcase
            end
         end
      endcase
      if (body_done) begin
`ifdef REFLET_LOADER_CHECKSUM_EN
         state_d = ST_CSUM;
`else
         state_d  = ST_REPLY;
         tx_vld_c = 1'b1;
         tx_dat_c = ACK_BYTE;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         len_q   <= 16'd0;
         ptr_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         hold_q  <= 1'b0;
         sum_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         hold_q  <= hold_d;
         sum_q   <= sum_d;
      end
   end

   assign bus.tx       = tx_line;
   assign bus.cpu_hold = hold_q;
   assign bus.addr     = addr_q;
   assign bus.data_out = data_q;
   assign bus.write_en = we_q;
endmodule

// File: tb/tb_reflet_uart_loader.sv
// Directed bench for the UART loader at 96 kHz / 9600 baud (10 clocks per bit).
module tb_reflet_uart_loader;
   localparam int DIV = 10;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   logic [15:0] wa_q[$];
   logic [15:0] wd_q[$];
   logic [7:0]  reply_q[$];
   logic [7:0]  frm[$];

   reflet_uart_loader_if #(.wordsize(16)) bus ();

   reflet_uart_loader #(.wordsize(16), .clk_freq(96000), .baud_rate(9600)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.write_en === 1'b1) begin
         wa_q.push_back(bus.addr);
         wd_q.push_back(bus.data_out);
      end
   end

   initial begin : tx_mon
      logic [7:0] b;
      b = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.tx === 1'b0) begin
            repeat (DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = bus.tx;
            end
            repeat (DIV) @(negedge clk);
            reply_q.push_back(b);
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] wa(input int i);
      return (i < wa_q.size()) ? wa_q[i] : 16'hxxxx;
   endfunction

   function automatic logic [15:0] wd(input int i);
      return (i < wd_q.size()) ? wd_q[i] : 16'hxxxx;
   endfunction

   function automatic logic [7:0] reply0();
      return (reply_q.size() > 0) ? reply_q[0] : 8'hxx;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         bus.rx = bits[i];
         repeat (DIV) @(negedge clk);
      end
      bus.rx = 1'b1;
   endtask

   task automatic send_frame();
      for (int i = 0; i < frm.size(); i++)
         send_byte(frm[i], 1'b1);
   endtask

   task automatic append_csum(input logic [7:0] delta);
`ifdef REFLET_LOADER_CHECKSUM_EN
      logic [7:0] s;
      s = 8'h00;
      for (int i = 1; i < frm.size(); i++)
         s = s + frm[i];
      frm.push_back(s ^ delta);
`else
      if (delta != 8'h00) frm.push_back(8'h00);
`endif
   endtask

   task automatic clear_obs();
      wa_q.delete();
      wd_q.delete();
      reply_q.delete();
   endtask

   task automatic wait_hold_low(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.cpu_hold === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.rx = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b, required 1", bus.tx); end
      checks++; if (bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL reset_hold: got %b, required 0", bus.cpu_hold); end
      checks++; if (bus.write_en !== 1'b0) begin failures++; $display("FAIL reset_we: got %b, required 0", bus.write_en); end
      checks++; if (bus.addr !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h, required 0000", bus.addr); end
      checks++; if (bus.data_out !== 16'h0000) begin failures++; $display("FAIL reset_data: got %h, required 0000", bus.data_out); end
      reset = 1'b0;
      clear_obs();
      repeat (2000) @(negedge clk);
      checks++; if (bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL idle_hold: got %b, required 0", bus.cpu_hold); end
      checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL idle_tx: got %b, required 1", bus.tx); end
      checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL idle_writes: got %0d, required 0", wa_q.size()); end
      checks++; if (reply_q.size() != 0) begin failures++; $display("FAIL idle_reply: got %0d bytes, required 0", reply_q.size()); end
   endtask

   task automatic test_load_ack();
      bit ok;
      clear_obs();
      frm = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h80, 8'h11, 8'h22};
      append_csum(8'h00);
      send_frame();
      checks++; if (bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL load_hold_during_reply: got %b, required 1", bus.cpu_hold); end
      wait_hold_low(ok);
      checks++; if (!ok) begin failures++; $display("FAIL load_hold_drop: cpu_hold=%b, required 0", bus.cpu_hold); end
      checks++; if (reply_q.size() != 1) begin failures++; $display("FAIL load_reply_count: got %0d, required 1", reply_q.size()); end
      checks++; if (reply0() !== 8'h06) begin failures++; $display("FAIL load_reply: got %h, required 06", reply0()); end
      checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL load_write_count: got %0d, required 2", wa_q.size()); end
      checks++; if (wa(0) !== 16'h8000 || wd(0) !== 16'h0011) begin failures++; $display("FAIL load_write0: got %h@%h, required 0011@8000", wd(0), wa(0)); end
      checks++; if (wa(1) !== 16'h8001 || wd(1) !== 16'h0022) begin failures++; $display("FAIL load_write1: got %h@%h, required 0022@8001", wd(1), wa(1)); end
      checks++; if (bus.addr !== 16'h8001 || bus.data_out !== 16'h0022) begin failures++; $display("FAIL load_bus_hold: got %h@%h, required 0022@8001", bus.data_out, bus.addr); end
   endtask

`ifdef REFLET_LOADER_CHECKSUM_EN
   task automatic test_bad_csum();
      bit ok;
      clear_obs();
      frm = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h80, 8'h11, 8'h22};
      append_csum(8'h01);
      send_frame();
      wait_hold_low(ok);
      checks++; if (!ok) begin failures++; $display("FAIL badcs_hold_drop: cpu_hold=%b, required 0", bus.cpu_hold); end
      checks++; if (reply0() !== 8'h15) begin failures++; $display("FAIL badcs_reply: got %h, required 15", reply0()); end
      checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL badcs_write_count: got %0d, required 2", wa_q.size()); end
   endtask
`endif

   task automatic test_leading_bytes();
      bit ok;
      clear_obs();
      frm = '{8'h3C, 8'h00};
      send_frame();
      checks++; if (bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL lead_hold: got %b, required 0", bus.cpu_hold); end
      frm = '{8'hA5, 8'h00, 8'h00, 8'hFF, 8'hFF};
      append_csum(8'h00);
      send_frame();
      wait_hold_low(ok);
      checks++; if (!ok) begin failures++; $display("FAIL lead_hold_drop: cpu_hold=%b, required 0", bus.cpu_hold); end
      checks++; if (reply0() !== 8'h06) begin failures++; $display("FAIL lead_reply: got %h, required 06", reply0()); end
      checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL lead_writes: got %0d, required 0", wa_q.size()); end
   endtask

   task automatic test_addr_wrap();
      bit ok;
      logic [15:0] ea [3];
      logic [15:0] ed [3];
      ea = '{16'hFFFF, 16'h0000, 16'h0001};
      ed = '{16'h00AA, 16'h00BB, 16'h00CC};
      clear_obs();
      frm = '{8'hA5, 8'h03, 8'h00, 8'hFF, 8'hFF, 8'hAA, 8'hBB, 8'hCC};
      append_csum(8'h00);
      send_frame();
      wait_hold_low(ok);
      checks++; if (reply0() !== 8'h06) begin failures++; $display("FAIL wrap_reply: got %h, required 06", reply0()); end
      checks++; if (wa_q.size() != 3) begin failures++; $display("FAIL wrap_write_count: got %0d, required 3", wa_q.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wa(i) !== ea[i] || wd(i) !== ed[i]) begin
            failures++;
            $display("FAIL wrap_write%0d: got %h@%h, required %h@%h", i, wd(i), wa(i), ed[i], ea[i]);
         end
      end
   endtask

   task automatic test_framing_error();
      bit ok;
      clear_obs();
      frm = '{8'hA5, 8'h01, 8'h00, 8'h34, 8'h12};
      send_frame();
      send_byte(8'h5A, 1'b0);
      wait_hold_low(ok);
      checks++; if (!ok) begin failures++; $display("FAIL ferr_hold_drop: cpu_hold=%b, required 0", bus.cpu_hold); end
      checks++; if (reply0() !== 8'h15) begin failures++; $display("FAIL ferr_reply: got %h, required 15", reply0()); end
      checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL ferr_writes: got %0d, required 0", wa_q.size()); end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      logic [7:0] partial;
      partial = 8'h11;
      clear_obs();
      frm = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h80};
      send_frame();
      bus.rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         bus.rx = partial[i];
         repeat (DIV) @(negedge clk);
      end
      checks++; if (bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL rstmid_hold_before: got %b, required 1", bus.cpu_hold); end
      reset = 1'b1;
      #1;
      checks++; if (bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL rstmid_hold: got %b, required 0", bus.cpu_hold); end
      checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL rstmid_tx: got %b, required 1", bus.tx); end
      @(negedge clk);
      bus.rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      checks++; if (reply_q.size() != 0) begin failures++; $display("FAIL rstmid_no_reply: got %0d bytes, required 0", reply_q.size()); end
      clear_obs();
      frm = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h80, 8'h11, 8'h22};
      append_csum(8'h00);
      send_frame();
      wait_hold_low(ok);
      checks++; if (reply0() !== 8'h06) begin failures++; $display("FAIL rstmid_reply: got %h, required 06", reply0()); end
      checks++; if (wa(0) !== 16'h8000 || wd(0) !== 16'h0011) begin failures++; $display("FAIL rstmid_write0: got %h@%h, required 0011@8000", wd(0), wa(0)); end
      checks++; if (wa(1) !== 16'h8001 || wd(1) !== 16'h0022) begin failures++; $display("FAIL rstmid_write1: got %h@%h, required 0022@8001", wd(1), wa(1)); end
   endtask

   initial begin
      test_reset();
      test_load_ack();
`ifdef REFLET_LOADER_CHECKSUM_EN
      test_bad_csum();
`endif
      test_leading_bytes();
      test_addr_wrap();
      test_framing_error();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
